// File: rtl/abus_slave_pkg.sv
// Shared abus encodings for the slave side: state constants for the target FSM.
// S_TOUT is only reachable when ABUS_SLAVE_TIMEOUT_EN is defined.
package abus_slave_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2,
        S_TOUT   = 2'd3
    } abus_slave_state_e;

endpackage

// File: rtl/abus_addr_decode.sv
// Combinational base-address window match for an abus target.
// Only the address bits above the window offset are presented.
module abus_addr_decode
    import abus_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    SPAN_BITS  = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                          req,
    input  logic [ADDR_WIDTH-1:SPAN_BITS] addr_hi,
    output logic                          hit
);

    assign hit = req && (addr_hi == BASE_ADDR[ADDR_WIDTH-1:SPAN_BITS]);

endmodule

// File: rtl/abus_slave.sv
// abus target endpoint: window decode, one-cycle register strobes, 4-phase ack.
// Optional access timeout is compiled in with ABUS_SLAVE_TIMEOUT_EN.
module abus_slave
    import abus_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    SPAN_BITS  = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    TIMEOUT    = 15
) (
    input  logic                  abus_clk,
    input  logic                  abus_rstb,
    input  logic                  abus_sreq,
    input  logic                  abus_swrite,
    input  logic                  abus_sread,
    input  logic                  abus_sabort,
    input  logic [ADDR_WIDTH-1:0] abus_saddress,
    input  logic [DATA_WIDTH-1:0] abus_swdata,
    output logic                  abus_sack,
    output logic [DATA_WIDTH-1:0] abus_srdata,
    output logic [SPAN_BITS-1:0]  reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
`ifdef ABUS_SLAVE_TIMEOUT_EN
    output logic                  reg_timeout,
`endif
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    input  logic                  reg_ready
);

    abus_slave_state_e     state_q, state_d;
    logic                  hit;
    logic                  is_read_q;
    logic                  aborted_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    abus_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .SPAN_BITS  (SPAN_BITS),
        .BASE_ADDR  (BASE_ADDR)
    ) u_decode (
        .req     (abus_sreq),
        .addr_hi (abus_saddress[ADDR_WIDTH-1:SPAN_BITS]),
        .hit     (hit)
    );

`ifdef ABUS_SLAVE_TIMEOUT_EN
    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q;
`endif

    // NOTE: next state gets its default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (hit && (abus_swrite || abus_sread)) state_d = S_ACCESS;
            S_ACCESS: begin
                if (reg_ready || abus_sabort) state_d = S_ACK;
`ifdef ABUS_SLAVE_TIMEOUT_EN
                else if (cnt_q == TOUT_LAST) state_d = S_TOUT;
`endif
            end
            S_ACK:    if (!abus_sreq) state_d = S_IDLE;
`ifdef ABUS_SLAVE_TIMEOUT_EN
            S_TOUT:   state_d = S_ACK;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge abus_clk or negedge abus_rstb) begin
        if (!abus_rstb) begin
            state_q   <= S_IDLE;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            is_read_q <= 1'b0;
            aborted_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            reg_we  <= 1'b0;
            reg_re  <= 1'b0;
            // Write wins when both phases are requested together.
            if (state_q == S_IDLE && state_d == S_ACCESS) begin
                reg_addr  <= abus_saddress[SPAN_BITS-1:0];
                reg_wdata <= abus_swdata;
                reg_we    <= abus_swrite;
                reg_re    <= !abus_swrite;
                is_read_q <= !abus_swrite;
                aborted_q <= 1'b0;
            end
            if (state_q == S_ACCESS && state_d == S_ACK) begin
                if (reg_ready) rdata_q   <= reg_rdata;
                else           aborted_q <= 1'b1;
            end
`ifdef ABUS_SLAVE_TIMEOUT_EN
            if (state_q == S_TOUT) rdata_q <= '1;
`endif
        end
    end

`ifdef ABUS_SLAVE_TIMEOUT_EN
    always_ff @(posedge abus_clk or negedge abus_rstb) begin
        if (!abus_rstb) begin
            cnt_q       <= '0;
            reg_timeout <= 1'b0;
        end else begin
            cnt_q <= (state_q == S_ACCESS && state_d == S_ACCESS) ? cnt_q + CNT_W'(1) : '0;
            if (state_q == S_TOUT) reg_timeout <= 1'b1;
        end
    end
`endif

    // Bus-facing outputs decode from registered state only; srdata stays wired-OR safe.
    assign abus_sack   = (state_q == S_ACK);
    assign abus_srdata = (abus_sack && is_read_q && !aborted_q) ? rdata_q : '0;

endmodule

// File: tb/tb_abus_slave.sv
// Self-checking bench for abus_slave: directed vector table, hand sequences,
// and randomized transactions scored against a transaction-level model.
module tb_abus_slave;

    localparam int          TOUT = 4;
    localparam logic [15:0] BASE = 16'h0040;
    localparam int          NEVER = 1000;

    logic        abus_clk = 1'b0;
    logic        abus_rstb;
    logic        abus_sreq, abus_swrite, abus_sread, abus_sabort;
    logic [15:0] abus_saddress, abus_swdata;
    logic        abus_sack;
    logic [15:0] abus_srdata;
    logic [3:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we, reg_re;
    logic [15:0] reg_rdata;
    logic        reg_ready;
`ifdef ABUS_SLAVE_TIMEOUT_EN
    logic        reg_timeout;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    abus_slave #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16),
        .SPAN_BITS  (4),
        .BASE_ADDR  (BASE),
        .TIMEOUT    (TOUT)
    ) dut (
        .abus_clk      (abus_clk),
        .abus_rstb     (abus_rstb),
        .abus_sreq     (abus_sreq),
        .abus_swrite   (abus_swrite),
        .abus_sread    (abus_sread),
        .abus_sabort   (abus_sabort),
        .abus_saddress (abus_saddress),
        .abus_swdata   (abus_swdata),
        .abus_sack     (abus_sack),
        .abus_srdata   (abus_srdata),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_we        (reg_we),
        .reg_re        (reg_re),
`ifdef ABUS_SLAVE_TIMEOUT_EN
        .reg_timeout   (reg_timeout),
`endif
        .reg_rdata     (reg_rdata),
        .reg_ready     (reg_ready)
    );

    always #5 abus_clk = ~abus_clk;

    // One transaction: request, local response timing, and expected bus outcome.
    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic        rd;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          rdy;     // cycles after the strobe cycle before reg_ready rises
        int          abt;     // same for sabort; -1 = no abort
        logic        acc;     // expected: access accepted
        logic [3:0]  exp_off;
        int          ack;     // expected cycle (1 = strobe cycle) in which sack is first high
        logic [15:0] exp_rd;  // expected srdata while acking
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge abus_clk);
        #1;
    endtask

    task automatic bus_idle();
        abus_sreq = 1'b0; abus_swrite = 1'b0; abus_sread = 1'b0; abus_sabort = 1'b0;
        reg_ready = 1'b0;
    endtask

    // Reference model: outcome from window arithmetic and first-event ordering.
    function automatic vec_t predict(input vec_t v);
        vec_t r = v;
        int   limit, a_eff;
`ifdef ABUS_SLAVE_TIMEOUT_EN
        limit = TOUT;
`else
        limit = NEVER;
`endif
        a_eff   = (v.abt < 0) ? NEVER : v.abt;
        r.acc   = ((v.addr >> 4) == (BASE >> 4)) && (v.wr || v.rd);
        r.exp_off = v.addr[3:0];
        r.exp_rd  = 16'h0;
        r.ack     = 0;
        if (r.acc) begin
            if (v.rdy <= a_eff && v.rdy + 1 <= limit) begin
                r.ack = v.rdy + 2;
                if (!v.wr) r.exp_rd = v.rdata;
            end else if (a_eff + 1 <= limit) begin
                r.ack = a_eff + 2;
            end else begin
                r.ack = limit + 2;
                if (!v.wr) r.exp_rd = 16'hFFFF;
            end
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v);
        abus_sreq = 1'b1; abus_swrite = v.wr; abus_sread = v.rd; abus_sabort = 1'b0;
        abus_saddress = v.addr; abus_swdata = v.wdata;
        reg_ready = 1'b0; reg_rdata = 16'($urandom);
        tick();
        check("strobe_we", reg_we, v.acc && v.wr);
        check("strobe_re", reg_re, v.acc && !v.wr);
        if (!v.acc) begin
            for (int t = 1; t <= 3; t++) begin
                check("miss_sack", abus_sack, 1'b0);
                check("miss_srdata", abus_srdata, 16'h0);
                if (t > 1) check("miss_strobe", reg_we | reg_re, 1'b0);
                tick();
            end
        end else begin
            check("reg_addr", reg_addr, v.exp_off);
            if (v.wr) check("reg_wdata", reg_wdata, v.wdata);
            for (int t = 1; t < v.ack; t++) begin
                check("pre_sack", abus_sack, 1'b0);
                check("pre_srdata", abus_srdata, 16'h0);
                if (t > 1) check("single_strobe", reg_we | reg_re, 1'b0);
                reg_ready   = (t >= 1 + v.rdy);
                reg_rdata   = reg_ready ? v.rdata : 16'($urandom);
                abus_sabort = (v.abt >= 0) && (t >= 1 + v.abt);
                tick();
            end
            check("ack_sack", abus_sack, 1'b1);
            check("ack_srdata", abus_srdata, v.exp_rd);
            check("ack_strobe", reg_we | reg_re, 1'b0);
            tick();
            check("ack_hold", abus_sack, 1'b1);
        end
        bus_idle();
        abus_swrite = 1'b0;
        tick();
        check("end_sack", abus_sack, 1'b0);
        check("end_srdata", abus_srdata, 16'h0);
    endtask

    vec_t tbl [11];

    initial begin
        vec_t v;
        bus_idle();
        abus_saddress = 16'h0; abus_swdata = 16'h0; reg_rdata = 16'h0;
        abus_rstb = 1'b0;

        //            addr      wr    rd    wdata     rdata     rdy  abt  acc  off   ack  exp_rd
        tbl[0]  = '{16'h0043, 1'b1, 1'b0, 16'hA5A5, 16'h0000, 0,   -1, 1'b1, 4'h3, 2, 16'h0000};
        tbl[1]  = '{16'h0045, 1'b0, 1'b1, 16'h0000, 16'h1234, 3,   -1, 1'b1, 4'h5, 5, 16'h1234};
        tbl[2]  = '{16'h0080, 1'b1, 1'b0, 16'h7777, 16'h0000, 0,   -1, 1'b0, 4'h0, 0, 16'h0000};
        tbl[3]  = '{16'h0047, 1'b0, 1'b1, 16'h0000, 16'hDEAD, 100,  2, 1'b1, 4'h7, 4, 16'h0000};
        tbl[4]  = '{16'h004F, 1'b1, 1'b1, 16'h0F0F, 16'hCAFE, 0,   -1, 1'b1, 4'hF, 2, 16'h0000};
        tbl[5]  = '{16'h0040, 1'b0, 1'b1, 16'h0000, 16'hBEEF, 0,   -1, 1'b1, 4'h0, 2, 16'hBEEF};
        tbl[6]  = '{16'h003F, 1'b0, 1'b1, 16'h0000, 16'h1111, 0,   -1, 1'b0, 4'h0, 0, 16'h0000};
        tbl[7]  = '{16'h0050, 1'b1, 1'b0, 16'h2222, 16'h0000, 0,   -1, 1'b0, 4'h0, 0, 16'h0000};
        tbl[8]  = '{16'h004A, 1'b0, 1'b1, 16'h0000, 16'h5A5A, 1,    1, 1'b1, 4'hA, 3, 16'h5A5A};
        tbl[9]  = '{16'h0041, 1'b0, 1'b1, 16'h0000, 16'h3C3C, 3,    0, 1'b1, 4'h1, 2, 16'h0000};
        tbl[10] = '{16'h0042, 1'b0, 1'b0, 16'h0000, 16'h0000, 0,   -1, 1'b0, 4'h0, 0, 16'h0000};

        #12;
        check("rst_sack", abus_sack, 1'b0);
        check("rst_srdata", abus_srdata, 16'h0);
        check("rst_strobes", {reg_we, reg_re}, 2'b00);
        check("rst_reg_addr", reg_addr, 4'h0);
        check("rst_reg_wdata", reg_wdata, 16'h0);
        abus_rstb = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) run_txn(tbl[i]);

        // Asynchronous reset while the read strobe is out.
        abus_sreq = 1'b1; abus_sread = 1'b1; abus_saddress = 16'h0046; reg_ready = 1'b0;
        tick();
        check("rst_pre_re", reg_re, 1'b1);
        check("rst_pre_addr", reg_addr, 4'h6);
        #2 abus_rstb = 1'b0;
        #1;
        check("rst_mid_re", reg_re, 1'b0);
        check("rst_mid_addr", reg_addr, 4'h0);
        check("rst_mid_sack", abus_sack, 1'b0);
        bus_idle();
        tick();
        abus_rstb = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            check("rst_no_restrobe", reg_we | reg_re, 1'b0);
            check("rst_post_sack", abus_sack, 1'b0);
        end
        run_txn(tbl[1]);

`ifdef ABUS_SLAVE_TIMEOUT_EN
        check("tout_initial", reg_timeout, 1'b0);
        v = '{16'h0041, 1'b0, 1'b1, 16'h0000, 16'h9999, 100, -1, 1'b1, 4'h1, TOUT + 2, 16'hFFFF};
        run_txn(v);
        check("tout_flag", reg_timeout, 1'b1);
        run_txn(tbl[0]);
        check("tout_sticky", reg_timeout, 1'b1);
`endif

        for (int i = 0; i < 40; i++) begin
            v.addr  = ($urandom_range(0, 1) == 1) ? {BASE[15:4], 4'($urandom)} : 16'($urandom);
            v.wr    = 1'($urandom);
            v.rd    = 1'($urandom);
            v.wdata = 16'($urandom);
            v.rdata = 16'($urandom);
            v.rdy   = $urandom_range(0, 6);
            v.abt   = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, 5)) : -1;
            run_txn(predict(v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule

// File: doc/abus_slave.md
Name: abus_slave

Overview:
- Target-side abus endpoint, directly downstream of the abus master stage.
- Decodes the shared bus request (req/write/read/abort/address/wdata) against a base-address window.
- Issues single-cycle register strobes to local logic, waits for local completion, and returns the 4-phase acknowledge plus read data to the bus.
- Read data is wired-OR friendly: it is all-zero whenever this slave is not acknowledging a read.

Parameters:
- ADDR_WIDTH, 16: bus address width.
- DATA_WIDTH, 16: bus data width.
- SPAN_BITS, 4: local offset width; the window size is 2**SPAN_BITS words; 1 <= SPAN_BITS < ADDR_WIDTH.
- BASE_ADDR, 16'h0000: window base; bits [SPAN_BITS-1:0] are ignored.
- TIMEOUT, 15: cycles to wait for reg_ready; used only with the optional feature; must be >= 1.

Ports:
- abus_clk, in, 1: bus clock; all state updates on the rising edge.
- abus_rstb, in, 1: asynchronous active-low reset.
- abus_sreq, in, 1: bus request (the master's abus_mreq).
- abus_swrite, in, 1: write phase.
- abus_sread, in, 1: read phase.
- abus_sabort, in, 1: abort phase.
- abus_saddress, in, ADDR_WIDTH: bus address; stable at the rising edge.
- abus_swdata, in, DATA_WIDTH: bus write data.
- abus_sack, out, 1: acknowledge to the master.
- abus_srdata, out, DATA_WIDTH: read data; zero when not in ACK with a read.
- reg_addr, out, SPAN_BITS: captured local offset.
- reg_wdata, out, DATA_WIDTH: captured write data.
- reg_we, out, 1: one-cycle write strobe.
- reg_re, out, 1: one-cycle read strobe.
- reg_rdata, in, DATA_WIDTH: local read data; valid while reg_ready is high.
- reg_ready, in, 1: local access complete; may be high in the same cycle as the strobe.

Behaviour:
- Reset values: all outputs 0; state S_IDLE; all capture registers 0.
- Reset mid-transaction: immediately return to S_IDLE with all outputs 0. No strobe is re-issued after reset.
- Hit condition: abus_sreq && abus_saddress[ADDR_WIDTH-1:SPAN_BITS] == BASE_ADDR[ADDR_WIDTH-1:SPAN_BITS].
- S_IDLE:
  - hit && (swrite || sread) -> S_ACCESS. Capture offset, wdata and direction; assert reg_we or reg_re for exactly the next cycle.
  - swrite && sread together: write has priority.
  - Abort, or a miss: stay in S_IDLE with no outputs.
- S_ACCESS:
  - reg_ready -> S_ACK. On a read, capture reg_rdata.
  - sabort while reg_ready is low -> S_ACK with no data captured (abort completion). An already-issued strobe is not retracted.
  - reg_ready and sabort in the same cycle: reg_ready wins; data is captured.
- S_ACK:
  - abus_sack = 1.
  - abus_srdata = captured data only if the access was a read and was not aborted; otherwise 0.
  - Stay until abus_sreq is sampled low, then go to S_IDLE.
  - abus_sack and abus_srdata fall in the first cycle of S_IDLE.
- Latency: request sampled at edge N -> strobe high in N+1. With reg_ready in N+1, abus_sack rises at N+2. Minimum back-to-back spacing is 4 cycles.
- Outputs are registered or decoded from state only; there is no combinational path from bus inputs to abus_sack.
- State encoding: S_IDLE, S_ACCESS, S_ACK, plus S_TOUT when the optional feature is compiled in.

Optional Feature:
- Macro: ABUS_SLAVE_TIMEOUT_EN.
- Defined:
  - A counter runs in S_ACCESS. After TIMEOUT cycles without reg_ready, go to S_TOUT, then S_ACK.
  - In this case abus_srdata is all-ones for a read.
  - Extra output reg_timeout (1 bit) goes high and stays high until reset.
  - Counter width is $clog2(TIMEOUT+1). The counter clears on leaving S_ACCESS.
- Undefined: no counter, no reg_timeout port; S_ACCESS waits indefinitely.

Decomposition:
- Shared abus encoding include: slave state constants (S_IDLE/S_ACCESS/S_ACK/S_TOUT), placed alongside the existing master state constants.
- Sub-module abus_addr_decode: combinational window match, parameterised on ADDR_WIDTH/SPAN_BITS/BASE_ADDR. Reused by the future interconnect.

Test Plan:
- Write: BASE_ADDR=16'h0040, write addr 16'h0043 data 16'hA5A5, reg_ready tied 1 -> reg_we one cycle with reg_addr=3, reg_wdata=16'hA5A5; abus_sack high 2 cycles after request; falls one cycle after sreq drops.
- Read: read 16'h0045, reg_ready after 3 cycles, reg_rdata=16'h1234 -> abus_srdata=16'h1234 only while abus_sack=1, 0 otherwise.
- Miss: access 16'h0080 -> no strobes, abus_sack stays 0, abus_srdata stays 0.
- Abort: read with reg_ready held 0, sabort after 2 cycles -> abus_sack=1 with abus_srdata=0; reg_re pulsed once only.
- Reset: abus_rstb low during S_ACCESS -> all outputs 0 immediately; the next request is handled normally.
- Timeout (ABUS_SLAVE_TIMEOUT_EN, TIMEOUT=4): read with reg_ready=0 -> abus_sack after the timeout, abus_srdata=16'hFFFF, reg_timeout=1 sticky.
